// File: rtl/ep_cpl_queue.sv
// ep_cpl_queue: completion-request queue between the PCIe RX and TX engines.
// RX pushes completion descriptors into a DEPTH-entry FIFO. A two-state
// dispatcher pops the head into output registers and holds req_compl_o until
// the TX engine reports compl_done_i. Also provides non-posted back-pressure,
// occupancy flags and a saturating count of dropped pushes.
module ep_cpl_queue #(
  parameter int DEPTH        = 8,
  parameter int AW           = 13,
  parameter int PFULL_MARGIN = 2,
  parameter int LW           = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  // descriptor push from the RX engine
  input  logic          req_compl_i,
  input  logic          req_compl_with_data_i,
  input  logic [2:0]    req_tc_i,
  input  logic          req_td_i,
  input  logic          req_ep_i,
  input  logic [1:0]    req_attr_i,
  input  logic [9:0]    req_len_i,
  input  logic [15:0]   req_rid_i,
  input  logic [7:0]    req_tag_i,
  input  logic [7:0]    req_be_i,
  input  logic [AW-1:0] req_addr_i,
  // registered head descriptor towards the TX engine
  output logic          req_compl_o,
  output logic          req_compl_with_data_o,
  output logic [2:0]    req_tc_o,
  output logic          req_td_o,
  output logic          req_ep_o,
  output logic [1:0]    req_attr_o,
  output logic [9:0]    req_len_o,
  output logic [15:0]   req_rid_o,
  output logic [7:0]    req_tag_o,
  output logic [7:0]    req_be_o,
  output logic [AW-1:0] req_addr_o,
  // retirement handshake
  input  logic          compl_done_i,
  output logic          compl_done_o,
  // status
  output logic          rx_np_ok_o,
  output logic [LW-1:0] level_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [7:0]    ovf_cnt_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int DW = 50 + AW;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  // Descriptor storage; no reset so it maps onto plain RAM.
  logic [DW-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [7:0]    ovf_cnt_q, ovf_cnt_d;
  logic          rx_np_ok_q, rx_np_ok_d;

  state_t        state_q, state_d;
  logic          req_compl_q, req_compl_d;
  logic          compl_done_q, compl_done_d;
  logic [DW-1:0] desc_q, desc_d;

  logic          full;
  logic          empty;
  logic          push_ok;
  logic          push_drop;
  logic          pop;
  logic [DW-1:0] wr_data;

  // Flags use the pre-edge level so a pop on the same edge cannot rescue a
  // push that arrives while full.
  assign full      = (level_q == LW'(DEPTH));
  assign empty     = (level_q == '0);
  assign push_ok   = req_compl_i && !full;
  assign push_drop = req_compl_i && full;
  assign pop       = (state_q == S_IDLE) && !empty;

  assign wr_data = {req_compl_with_data_i, req_tc_i, req_td_i, req_ep_i,
                    req_attr_i, req_len_i, req_rid_i, req_tag_i, req_be_i,
                    req_addr_i};

  // Write port: accepted pushes land at the write pointer.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  // Pointer, occupancy, overflow and back-pressure next-state.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ovf_cnt_d = ovf_cnt_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push_drop && (ovf_cnt_q != 8'hFF)) begin
      ovf_cnt_d = ovf_cnt_q + 8'd1;
    end
    level_d    = level_q + LW'(push_ok) - LW'(pop);
    rx_np_ok_d = (level_d < LW'(DEPTH - PFULL_MARGIN));
  end

  // Queue state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_cnt_q  <= '0;
      rx_np_ok_q <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_cnt_q  <= ovf_cnt_d;
      rx_np_ok_q <= rx_np_ok_d;
    end
  end

  // Dispatcher next-state: IDLE loads the head and raises the request,
  // BUSY holds everything until the TX engine retires it.
  always_comb begin
    state_d      = state_q;
    req_compl_d  = req_compl_q;
    compl_done_d = 1'b0;
    desc_d       = desc_q;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          desc_d      = mem[rd_ptr_q];
          req_compl_d = 1'b1;
          state_d     = S_BUSY;
        end
      end
      S_BUSY: begin
        if (compl_done_i) begin
          req_compl_d  = 1'b0;
          compl_done_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Dispatcher registers; reset discards any in-flight descriptor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      req_compl_q  <= 1'b0;
      compl_done_q <= 1'b0;
      desc_q       <= '0;
    end else begin
      state_q      <= state_d;
      req_compl_q  <= req_compl_d;
      compl_done_q <= compl_done_d;
      desc_q       <= desc_d;
    end
  end

  assign {req_compl_with_data_o, req_tc_o, req_td_o, req_ep_o, req_attr_o,
          req_len_o, req_rid_o, req_tag_o, req_be_o, req_addr_o} = desc_q;

  assign req_compl_o  = req_compl_q;
  assign compl_done_o = compl_done_q;
  assign rx_np_ok_o   = rx_np_ok_q;
  assign level_o      = level_q;
  assign full_o       = full;
  assign empty_o      = empty;
  assign ovf_cnt_o    = ovf_cnt_q;

endmodule

// File: tb/tb_ep_cpl_queue.sv
// Testbench for ep_cpl_queue: hand-derived vector table, directed corner
// sequences and a randomized phase compared against a queue-based model.
module tb_ep_cpl_queue;

  localparam int DEPTH        = 8;
  localparam int AW           = 13;
  localparam int PFULL_MARGIN = 2;
  localparam int LW           = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic          wd;
    logic [2:0]    tc;
    logic          td;
    logic          ep;
    logic [1:0]    attr;
    logic [9:0]    len;
    logic [15:0]   rid;
    logic [7:0]    tag;
    logic [7:0]    be;
    logic [AW-1:0] addr;
  } desc_t;

  typedef struct {
    logic          push;
    logic [7:0]    tag;
    logic          done;
    logic          exp_req;
    logic          exp_cd;
    logic [LW-1:0] exp_level;
    logic          exp_empty;
    logic          chk_tag;
    logic [7:0]    exp_tag;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic req_compl_i;
  logic compl_done_i;
  desc_t din;
  desc_t dout;

  logic          req_compl_o;
  logic          req_compl_with_data_o;
  logic [2:0]    req_tc_o;
  logic          req_td_o;
  logic          req_ep_o;
  logic [1:0]    req_attr_o;
  logic [9:0]    req_len_o;
  logic [15:0]   req_rid_o;
  logic [7:0]    req_tag_o;
  logic [7:0]    req_be_o;
  logic [AW-1:0] req_addr_o;
  logic          compl_done_o;
  logic          rx_np_ok_o;
  logic [LW-1:0] level_o;
  logic          full_o;
  logic          empty_o;
  logic [7:0]    ovf_cnt_o;

  always #5 clk = ~clk;

  ep_cpl_queue #(
    .DEPTH(DEPTH), .AW(AW), .PFULL_MARGIN(PFULL_MARGIN)
  ) dut (
    .clk(clk), .rst(rst),
    .req_compl_i(req_compl_i),
    .req_compl_with_data_i(din.wd), .req_tc_i(din.tc), .req_td_i(din.td),
    .req_ep_i(din.ep), .req_attr_i(din.attr), .req_len_i(din.len),
    .req_rid_i(din.rid), .req_tag_i(din.tag), .req_be_i(din.be),
    .req_addr_i(din.addr),
    .req_compl_o(req_compl_o),
    .req_compl_with_data_o(req_compl_with_data_o), .req_tc_o(req_tc_o),
    .req_td_o(req_td_o), .req_ep_o(req_ep_o), .req_attr_o(req_attr_o),
    .req_len_o(req_len_o), .req_rid_o(req_rid_o), .req_tag_o(req_tag_o),
    .req_be_o(req_be_o), .req_addr_o(req_addr_o),
    .compl_done_i(compl_done_i), .compl_done_o(compl_done_o),
    .rx_np_ok_o(rx_np_ok_o), .level_o(level_o), .full_o(full_o),
    .empty_o(empty_o), .ovf_cnt_o(ovf_cnt_o)
  );

  assign dout = {req_compl_with_data_o, req_tc_o, req_td_o, req_ep_o,
                 req_attr_o, req_len_o, req_rid_o, req_tag_o, req_be_o,
                 req_addr_o};

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of waiting descriptors plus the one in flight.
  desc_t      mq[$];
  logic       m_busy;
  desc_t      m_cur;
  logic [7:0] m_ovf;
  logic       m_cd;
  logic       m_npok;

  // Expected values for the fill sequence (10 pushes, TX stalled).
  int fl_lvl [10] = '{1, 1, 2, 3, 4, 5, 6, 7, 8, 8};
  int fl_np  [10] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
  int fl_full[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
  int fl_ovf [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

  vec_t tbl[11];

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic desc_t mk(input logic [7:0] tag);
    desc_t d;
    d      = '0;
    d.wd   = 1'b1;
    d.len  = 10'd1;
    d.rid  = 16'h0100;
    d.be   = 8'h0F;
    d.addr = 13'h0040;
    d.tag  = tag;
    return d;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_busy = 1'b0;
    m_cur  = '0;
    m_ovf  = 8'd0;
    m_cd   = 1'b0;
    m_npok = 1'b1;
  endtask

  // One clock edge of the queue's behaviour, from the values held before it.
  task automatic model_edge();
    int pre_size;
    if (rst) begin
      model_reset();
    end else begin
      pre_size = mq.size();
      m_cd = 1'b0;
      if (m_busy) begin
        if (compl_done_i) begin
          m_busy = 1'b0;
          m_cd   = 1'b1;
        end
      end else if (pre_size > 0) begin
        m_cur  = mq.pop_front();
        m_busy = 1'b1;
      end
      if (req_compl_i) begin
        if (pre_size < DEPTH) mq.push_back(din);
        else if (m_ovf != 8'hFF) m_ovf = m_ovf + 8'd1;
      end
      m_npok = (mq.size() < DEPTH - PFULL_MARGIN);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cmp_model(input string name);
    logic [127:0] a;
    logic [127:0] e;
    a = 128'({req_compl_o, compl_done_o, rx_np_ok_o, full_o, empty_o,
              level_o, ovf_cnt_o, dout});
    e = 128'({m_busy, m_cd, m_npok, (mq.size() == DEPTH), (mq.size() == 0),
              LW'(mq.size()), m_ovf, m_cur});
    chk(name, a, e);
  endtask

  task automatic idle_inputs();
    req_compl_i  = 1'b0;
    compl_done_i = 1'b0;
    din          = '0;
  endtask

  initial begin
    int next_tag;
    int retired;
    int req_cnt;
    int budget;
    logic [63:0] r;

    // push, tag, done | req, cd, level, empty, chk_tag, tag
    tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, LW'(1), 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, LW'(0), 1'b1, 1'b1, 8'h11};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, LW'(0), 1'b1, 1'b1, 8'h11};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, LW'(0), 1'b1, 1'b0, 8'h00};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, LW'(0), 1'b1, 1'b0, 8'h00};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, LW'(0), 1'b1, 1'b0, 8'h00};
    tbl[6]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, LW'(1), 1'b0, 1'b0, 8'h00};
    tbl[7]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, LW'(1), 1'b0, 1'b1, 8'h22};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, LW'(1), 1'b0, 1'b1, 8'h22};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, LW'(0), 1'b1, 1'b1, 8'h33};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, LW'(0), 1'b1, 1'b1, 8'h33};

    rst = 1'b1;
    idle_inputs();
    model_reset();
    step();
    step();
    rst = 1'b0;
    step();

    // Reset state.
    chk("reset_state",
        128'({req_compl_o, compl_done_o, rx_np_ok_o, full_o, empty_o, level_o, ovf_cnt_o}),
        128'({1'b0, 1'b0, 1'b1, 1'b0, 1'b1, LW'(0), 8'd0}));

    // Vector table: single descriptor, ignored done in IDLE, back-to-back pair.
    for (int i = 0; i < 11; i++) begin
      req_compl_i  = tbl[i].push;
      din          = tbl[i].push ? mk(tbl[i].tag) : '0;
      compl_done_i = tbl[i].done;
      step();
      $display("vec %0d push=%0d tag=%02h done=%0d -> req=%0d cd=%0d level=%0d tag_o=%02h",
               i, tbl[i].push, tbl[i].tag, tbl[i].done, req_compl_o,
               compl_done_o, level_o, req_tag_o);
      chk($sformatf("vec%0d_req", i), 128'(req_compl_o), 128'(tbl[i].exp_req));
      chk($sformatf("vec%0d_cd", i), 128'(compl_done_o), 128'(tbl[i].exp_cd));
      chk($sformatf("vec%0d_level", i), 128'(level_o), 128'(tbl[i].exp_level));
      chk($sformatf("vec%0d_empty", i), 128'(empty_o), 128'(tbl[i].exp_empty));
      if (tbl[i].chk_tag)
        chk($sformatf("vec%0d_tag", i), 128'(req_tag_o), 128'(tbl[i].exp_tag));
      if (i == 1 || i == 2)
        chk($sformatf("vec%0d_fields", i),
            128'({req_compl_with_data_o, req_len_o, req_addr_o}),
            128'({1'b1, 10'd1, 13'h0040}));
      cmp_model($sformatf("vec%0d_model", i));
    end
    idle_inputs();

    // Fill with TX stalled: 10 pushes, one rejected, threshold crossing.
    for (int i = 0; i < 10; i++) begin
      req_compl_i = 1'b1;
      din         = mk(8'(8'h40 + i));
      step();
      $display("fill %0d level=%0d full=%0d np_ok=%0d ovf=%0d",
               i, level_o, full_o, rx_np_ok_o, ovf_cnt_o);
      chk($sformatf("fill%0d_level", i), 128'(level_o), 128'(fl_lvl[i]));
      chk($sformatf("fill%0d_np_ok", i), 128'(rx_np_ok_o), 128'(fl_np[i]));
      chk($sformatf("fill%0d_full", i), 128'(full_o), 128'(fl_full[i]));
      chk($sformatf("fill%0d_ovf", i), 128'(ovf_cnt_o), 128'(fl_ovf[i]));
      cmp_model($sformatf("fill%0d_model", i));
    end
    idle_inputs();

    // Drain in order; level 6 keeps np_ok low, level 5 raises it.
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("drain%0d_req", k), 128'(req_compl_o), 128'(1));
      chk($sformatf("drain%0d_tag", k), 128'(req_tag_o), 128'(8'h40 + k));
      compl_done_i = 1'b1;
      step();
      chk($sformatf("drain%0d_cd", k), 128'(compl_done_o), 128'(1));
      compl_done_i = 1'b0;
      step();
      $display("drain %0d level=%0d np_ok=%0d req=%0d tag_o=%02h",
               k, level_o, rx_np_ok_o, req_compl_o, req_tag_o);
      if (k == 1)
        chk("thresh_at6", 128'({level_o, rx_np_ok_o}), 128'({LW'(6), 1'b0}));
      if (k == 2)
        chk("thresh_at5", 128'({level_o, rx_np_ok_o}), 128'({LW'(5), 1'b1}));
      cmp_model($sformatf("drain%0d_model", k));
    end
    chk("drain_end", 128'({req_compl_o, level_o, ovf_cnt_o}),
        128'({1'b0, LW'(0), 8'd1}));

    // Simultaneous push and pop at level 3.
    for (int i = 0; i < 4; i++) begin
      req_compl_i = 1'b1;
      din         = mk(8'(8'h60 + i));
      step();
    end
    req_compl_i  = 1'b0;
    compl_done_i = 1'b1;
    step();
    chk("pp_pre", 128'({level_o, req_compl_o, compl_done_o}),
        128'({LW'(3), 1'b0, 1'b1}));
    compl_done_i = 1'b0;
    req_compl_i  = 1'b1;
    din          = mk(8'h64);
    step();
    $display("pushpop level=%0d req=%0d tag_o=%02h", level_o, req_compl_o, req_tag_o);
    chk("pp_level", 128'(level_o), 128'(3));
    chk("pp_req", 128'({req_compl_o, req_tag_o}), 128'({1'b1, 8'h61}));
    cmp_model("pp_model");

    // Reset mid-BUSY at level 4, asserted between clock edges.
    din = mk(8'h65);
    step();
    idle_inputs();
    chk("rb_pre", 128'({req_compl_o, level_o}), 128'({1'b1, LW'(4)}));
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    $display("async reset req=%0d level=%0d ovf=%0d np_ok=%0d", req_compl_o,
             level_o, ovf_cnt_o, rx_np_ok_o);
    chk("rb_async",
        128'({req_compl_o, compl_done_o, rx_np_ok_o, full_o, empty_o, level_o, ovf_cnt_o, dout}),
        128'({1'b1 ^ 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, LW'(0), 8'd0, 63'd0}));
    #2;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("rb_post%0d_req", i), 128'({req_compl_o, level_o}),
          128'({1'b0, LW'(0)}));
      cmp_model($sformatf("rb_post%0d_model", i));
    end

    // Wrap-around: 20 tags, TX acks 3 cycles after each request.
    next_tag = 0;
    retired  = 0;
    req_cnt  = 0;
    budget   = 0;
    while (retired < 20 && budget < 600) begin
      req_compl_i  = (next_tag < 20) && !full_o;
      din          = mk(8'(next_tag));
      compl_done_i = req_compl_o && (req_cnt == 3);
      if (compl_done_i) begin
        $display("wrap retire tag=%0d expected=%0d", req_tag_o, retired);
        chk($sformatf("wrap_tag%0d", retired), 128'(req_tag_o), 128'(retired));
        retired++;
      end
      step();
      if (req_compl_i) next_tag++;
      req_cnt = req_compl_o ? req_cnt + 1 : 0;
      cmp_model("wrap_model");
      budget++;
    end
    idle_inputs();
    chk("wrap_count", 128'(retired), 128'(20));
    chk("wrap_ovf", 128'(ovf_cnt_o), 128'(0));

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      r            = {$urandom, $urandom};
      req_compl_i  = ($urandom_range(0, 99) < 60);
      din          = r[62:0];
      compl_done_i = ($urandom_range(0, 99) < 35);
      step();
      cmp_model($sformatf("rand%0d", i));
    end
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ep_cpl_queue.md
# ep_cpl_queue

Parametrised completion-request queue between the PCIe RX engine and TX engine of the endpoint. It accepts completion descriptors from the RX engine, buffers them in an internal FIFO of configurable depth and address width, and issues them one at a time to the TX engine with a hold-until-done handshake. It also drives `rx_np_ok_o` back-pressure from a programmable threshold, and exposes occupancy and an overflow counter.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥4.
- `AW`, 13: width of the request address field.
- `PFULL_MARGIN`, 2: `rx_np_ok_o` drops when level ≥ `DEPTH-PFULL_MARGIN`; range 1..`DEPTH-1`.
- `LW`, `$clog2(DEPTH)+1`: level width; derived, not overridden.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_compl_i` in 1: push strobe, one descriptor per cycle high.
- `req_compl_with_data_i` in 1: descriptor needs CplD (1) or Cpl (0).
- `req_tc_i` in 3, `req_td_i` in 1, `req_ep_i` in 1, `req_attr_i` in 2: TLP header fields.
- `req_len_i` in 10, `req_rid_i` in 16, `req_tag_i` in 8, `req_be_i` in 8: TLP header fields.
- `req_addr_i` in `AW`: lower address.
- `req_compl_o` out 1: request to TX engine; held until done.
- `req_compl_with_data_o` out 1: registered copy of the head entry's flag.
- `req_tc_o`..`req_addr_o` out, same widths as inputs: registered head descriptor.
- `compl_done_i` in 1: TX engine finished the current completion.
- `compl_done_o` out 1: one-cycle pulse to the RX engine per retired descriptor.
- `rx_np_ok_o` out 1: registered non-posted back-pressure to the core.
- `level_o` out `LW`: current FIFO occupancy, 0..`DEPTH`.
- `full_o` out 1: FIFO full.
- `empty_o` out 1: FIFO empty.
- `ovf_cnt_o` out 8: count of rejected pushes; saturates at 255.

## Operation
- **Storage.** Descriptor width is 50+`AW` bits. Memory is `DEPTH` × width, written at `wr_ptr` and read at `rd_ptr`. Pointers wrap modulo `DEPTH`. `level` counts 0..`DEPTH`.
- **Push.**
  - `req_compl_i` && !`full` (pre-edge value): write the entry, increment `wr_ptr`.
  - `req_compl_i` && `full`: entry dropped; `ovf_cnt_o` += 1, saturating at 255.
- **Dispatch FSM:**
  - IDLE: if !`empty`, load the head into the output registers, pop (increment `rd_ptr`), set `req_compl_o`=1, go to BUSY.
  - BUSY: hold `req_compl_o` and all descriptor outputs stable. On `compl_done_i`: `req_compl_o`=0, `compl_done_o`=1 for one cycle, go to IDLE.
  - `compl_done_i` in IDLE is ignored.
- **Level update.** Simultaneous push and pop on a non-full FIFO leaves `level` unchanged. A pop on the same edge as a rejected push does not rescue that push.
- **Flags.** `rx_np_ok_o` is registered as (`level_next` < `DEPTH-PFULL_MARGIN`). `full_o` = (`level`==`DEPTH`). `empty_o` = (`level`==0).
- **Reset.** `rst` at any time, including in BUSY, clears:
  - pointers, level and FSM (to IDLE);
  - `ovf_cnt_o`, `req_compl_o`, `compl_done_o`, all descriptor outputs (to 0);
  - sets `rx_np_ok_o`=1.
  - Queued and in-flight descriptors are discarded.

## Timing
- **Push visibility.** A push on edge N is reflected in `level_o` and `empty_o` after edge N.
- **Dispatch latency.** IDLE sees non-empty in cycle N+1, so `req_compl_o` and descriptor outputs are valid after edge N+1. Minimum push-to-request latency is 2 edges.
- **Retirement.** `compl_done_i` sampled high at edge M: `req_compl_o` is low and `compl_done_o` is high after M. The next request can assert after edge M+1 at the earliest, giving a maximum throughput of one descriptor per 2 cycles.
- **Back-pressure.** `rx_np_ok_o` updates on the same edge as `level_o`.

## Test plan
- **Single descriptor.** Push tag=0x11, len=1, with_data=1, addr=0x0040 at edge 0. Required: `req_compl_o`=1 after edge 1 with those exact fields, stable until `compl_done_i`. Then one `compl_done_o` pulse and `level_o`=0.
- **Fill and overflow.** DEPTH=8, TX stalled (no `compl_done_i`), push 10 descriptors back-to-back. Required:
  - `level_o` peaks at 8 (one entry is in the output registers);
  - `full_o`=1;
  - `ovf_cnt_o` equals pushes rejected while full;
  - order preserved on drain.
- **Back-pressure threshold.** DEPTH=8, PFULL_MARGIN=2: `rx_np_ok_o` falls when level reaches 6 and rises when level drops to 5.
- **Wrap-around.** Stream 20 descriptors with tags 0..19, TX acking 3 cycles after each request. Required: tags retire in order 0..19 with no loss.
- **Simultaneous push/pop.** Level=3, push on the same edge IDLE pops. Required: level stays 3.
- **Reset mid-BUSY.** Assert `rst` while `req_compl_o`=1 with level=4. Required: all outputs go to reset values asynchronously; after release, no request issues without a new push.
